// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter_if
// Description : Bundle of the fetch port, loader/debug port and single-port
//               instruction-memory signals around imem_port_arbiter.
//               slave  = the arbiter side, master = requesters plus memory.
// Revision    : 1.0  initial release
// ============================================================================
interface imem_port_arbiter_if #(
    parameter int DEPTH_LOG2 = 8
);
    // Fetch port (read-only)
    logic                  f_req;
    logic [31:0]           f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [31:0]           f_rdata;
    // Loader / debug port (read/write)
    logic                  l_req;
    logic                  l_we;
    logic [31:0]           l_addr;
    logic [31:0]           l_wdata;
    logic                  l_gnt;
    logic                  l_rvalid;
    logic [31:0]           l_rdata;
    // Memory side
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    // Status
    logic                  err_misalign;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output err_misalign
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  err_misalign
    );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter
// Description : Two-requester arbiter/sequencer for the single-port
//               instruction memory. Loader has priority over fetch except
//               when fetch has been denied STARVE_MAX consecutive cycles.
//               Read data returns registered one cycle after the grant.
//               Optional feature macro: IMEM_ARB_ALIGN_CHK_EN (misaligned
//               accesses are consumed without touching memory, sticky flag).
// Revision    : 1.0  initial release
// ============================================================================
module imem_port_arbiter #(
    parameter int DEPTH_LOG2 = 8,
    parameter int STARVE_MAX = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    imem_port_arbiter_if.slave   bus
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]            r_starve_cnt;
    logic [DEPTH_LOG2-1:0] r_mem_addr;
    logic                  r_f_rvalid;
    logic [31:0]           r_f_rdata;
    logic                  r_l_rvalid;
    logic [31:0]           r_l_rdata;
    logic                  r_err_misalign;

    logic                  w_starved;
    logic                  w_f_gnt;
    logic                  w_l_gnt;
    logic                  w_any_gnt;
    logic [31:0]           w_sel_addr;
    logic [DEPTH_LOG2-1:0] w_sel_idx;
    logic                  w_misalign;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // Grants are gated by rst_n so nothing is granted while reset is held.
    assign w_starved  = (r_starve_cnt == c_STARVE_MAX);
    assign w_f_gnt    = rst_n & bus.f_req & (~bus.l_req | w_starved);
    assign w_l_gnt    = rst_n & bus.l_req & ~w_f_gnt;
    assign w_any_gnt  = w_f_gnt | w_l_gnt;
    assign w_sel_addr = w_f_gnt ? bus.f_addr : bus.l_addr;
    // Upper address bits are dropped, so indices wrap modulo the depth.
    assign w_sel_idx  = w_sel_addr[DEPTH_LOG2+1:2];

`ifdef IMEM_ARB_ALIGN_CHK_EN
    assign w_misalign       = w_any_gnt & (w_sel_addr[1:0] != 2'b00);
    assign bus.err_misalign = r_err_misalign;
`else
    assign w_misalign       = 1'b0;
    assign bus.err_misalign = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored.
    assign w_unused = &{1'b0, w_sel_addr, r_err_misalign};

    // A misaligned read returns zero instead of memory content.
    assign w_rdata = w_misalign ? 32'h0 : bus.mem_rdata;

    assign bus.f_gnt     = w_f_gnt;
    assign bus.l_gnt     = w_l_gnt;
    assign bus.mem_addr  = w_any_gnt ? w_sel_idx : r_mem_addr;
    assign bus.mem_we    = w_l_gnt & bus.l_we & ~w_misalign;
    assign bus.mem_wdata = bus.l_wdata;
    assign bus.f_rvalid  = r_f_rvalid;
    assign bus.f_rdata   = r_f_rdata;
    assign bus.l_rvalid  = r_l_rvalid;
    assign bus.l_rdata   = r_l_rdata;

    // Count consecutive denied fetch cycles, saturating at STARVE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (bus.f_req && !w_f_gnt) begin
            if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    // Remember the last granted index so mem_addr holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= '0;
        end else if (w_any_gnt) begin
            r_mem_addr <= w_sel_idx;
        end
    end

    // Fetch response: valid one cycle after grant, data held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_rvalid <= 1'b0;
            r_f_rdata  <= 32'h0;
        end else begin
            r_f_rvalid <= w_f_gnt;
            if (w_f_gnt) begin
                r_f_rdata <= w_rdata;
            end
        end
    end

    // Loader response: only reads produce a response beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l_rvalid <= 1'b0;
            r_l_rdata  <= 32'h0;
        end else begin
            r_l_rvalid <= w_l_gnt & ~bus.l_we;
            if (w_l_gnt && !bus.l_we) begin
                r_l_rdata <= w_rdata;
            end
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_misalign <= 1'b0;
        end else if (w_misalign) begin
            r_err_misalign <= 1'b1;
        end
    end

endmodule
`default_nettype wire
